// File: rtl/alu_64_sequencer.sv
// alu_64_sequencer: buffers ALU commands in a small FIFO and drives the
// ALU_64 initiator handshake (bgn / in_0 / in_1 / sel, wait for stop) one
// operation at a time, returning each result on a valid/ready port.
// A watchdog turns a missing stop into an error result.
module alu_64_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_sel,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    output logic        bgn,
    output logic [63:0] in_0,
    output logic [63:0] in_1,
    output logic [4:0]  sel,
    input  logic        stop,
    input  logic [63:0] out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [4:0]  res_sel,
    output logic        res_err,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Watchdog value at which the TIMEOUT-th WAIT sample is being taken.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [4:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          fifo_q [DEPTH];
    cmd_t          fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   in_0_q, in_0_d;
    logic [63:0]   in_1_q, in_1_d;
    logic [4:0]    sel_q, sel_d;
    logic [63:0]   res_data_q, res_data_d;
    logic [4:0]    res_sel_q, res_sel_d;
    logic          res_err_q, res_err_d;
    logic [15:0]   wd_q, wd_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          wd_expire;
    cmd_t          head;

    // FIFO status and handshake qualifiers
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        push       = cmd_valid && !fifo_full;
        pop        = (state_q == S_IDLE) && !fifo_empty;
        head       = fifo_q[rd_ptr_q];
        wd_expire  = (wd_q == WD_LAST);
    end

    // FIFO storage write and pointer/occupancy update
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{sel: cmd_sel, a: cmd_a, b: cmd_b};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (stop || wd_expire) state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-derived and registered outputs
    always_comb begin
        cmd_ready = !fifo_full;
        bgn       = (state_q == S_ISSUE);
        res_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE) || !fifo_empty;
        in_0      = in_0_q;
        in_1      = in_1_q;
        sel       = sel_q;
        res_data  = res_data_q;
        res_sel   = res_sel_q;
        res_err   = res_err_q;
        err_cnt   = err_cnt_q;
    end

    // Operand load, watchdog and result capture
    always_comb begin
        in_0_d     = in_0_q;
        in_1_d     = in_1_q;
        sel_d      = sel_q;
        wd_d       = wd_q;
        res_data_d = res_data_q;
        res_sel_d  = res_sel_q;
        res_err_d  = res_err_q;
        err_cnt_d  = err_cnt_q;
        if (pop) begin
            in_0_d = head.a;
            in_1_d = head.b;
            sel_d  = head.sel;
        end
        unique case (state_q)
            S_ISSUE: wd_d = '0;
            S_WAIT: begin
                // stop on the expiring edge still counts as a normal result
                if (stop) begin
                    res_data_d = out;
                    res_sel_d  = sel_q;
                    res_err_d  = 1'b0;
                end else if (wd_expire) begin
                    res_data_d = '0;
                    res_sel_d  = sel_q;
                    res_err_d  = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and FIFO control registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_0_q     <= '0;
            in_1_q     <= '0;
            sel_q      <= '0;
            wd_q       <= '0;
            res_data_q <= '0;
            res_sel_q  <= '0;
            res_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_0_q     <= in_0_d;
            in_1_q     <= in_1_d;
            sel_q      <= sel_d;
            wd_q       <= wd_d;
            res_data_q <= res_data_d;
            res_sel_q  <= res_sel_d;
            res_err_q  <= res_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: doc/alu_64_sequencer.md
# alu_64_sequencer

Command initiator for the 64-bit ALU: accepts operation requests (`sel`, two operands) into a small FIFO, drives the ALU `bgn`/`in_0`/`in_1`/`sel` handshake one operation at a time, waits for `stop`, and returns `out` on a valid/ready result port. It sits between a controller and the `ALU_64` instance, owning the initiator side of the ALU protocol. A watchdog aborts operations whose `stop` never arrives.

## Interface
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `TIMEOUT`, 255, max WAIT cycles before abort (1..65535)

Ports:
- `clk` input 1, single clock, rising edge
- `rst_b` input 1, asynchronous active-low reset
- `cmd_valid` input 1, command present
- `cmd_ready` output 1, FIFO not full
- `cmd_sel` input 5, ALU operation code
- `cmd_a` input 64, operand 0
- `cmd_b` input 64, operand 1
- `bgn` output 1, ALU start pulse
- `in_0` output 64, ALU operand 0
- `in_1` output 64, ALU operand 1
- `sel` output 5, ALU operation select
- `stop` input 1, ALU done / `out` valid
- `out` input 64, ALU result
- `res_valid` output 1, result held
- `res_ready` input 1, consumer accepts result
- `res_data` output 64, captured ALU result (0 on timeout)
- `res_sel` output 5, op code of returned result
- `res_err` output 1, result is a timeout abort
- `busy` output 1, FSM not IDLE or FIFO non-empty
- `err_cnt` output 8, saturating timeout count

## Operation
- Command FIFO: push on `cmd_valid && cmd_ready`; `cmd_ready = !full` (combinational). Push and pop in the same cycle allowed, including when full (pop frees slot next cycle only; `cmd_ready` stays 0 that cycle). Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: FIFO non-empty → pop head into `in_0`/`in_1`/`sel` registers, go ISSUE.
  - ISSUE (1 cycle): `bgn=1`; clear watchdog; go WAIT.
  - WAIT: `bgn=0`; operands/`sel` held stable. `stop` sampled high → capture `out` into `res_data`, `res_sel=sel`, `res_err=0`, go DONE. Else watchdog increments; when watchdog reaches TIMEOUT with `stop` still low → `res_data=0`, `res_err=1`, `err_cnt` +1 (saturate at 255), go DONE.
  - DONE: `res_valid=1`; on `res_ready` → IDLE (next command not popped in the same cycle).
- `stop` is ignored in IDLE, ISSUE and DONE; stale `stop` from a previous op is never sampled because WAIT starts after `bgn`.
- `in_0`/`in_1`/`sel` keep last issued values in IDLE/DONE.
- `res_data`/`res_sel`/`res_err` stable while `res_valid=1`.
- `busy = (state != IDLE) || !empty`.

## Timing
- Reset (async, immediate): `bgn=0`, `in_0=0`, `in_1=0`, `sel=0`, `res_valid=0`, `res_data=0`, `res_sel=0`, `res_err=0`, `err_cnt=0`, FIFO empty so `cmd_ready=1`, `busy=0`, state IDLE.
- Reset mid-operation: in-flight op and queued commands discarded, no result produced; `bgn` drops immediately.
- Command pushed at edge E (FIFO was empty, FSM IDLE): pop at E+1 (ISSUE entered), `bgn` high between E+1 and E+2, WAIT from E+2.
- `stop` high at edge E+2+k (k≥0) → `res_valid` high after that edge; minimum push-to-`res_valid` = 3 cycles.
- Timeout: `res_valid` rises TIMEOUT cycles after WAIT entry if `stop` never sampled high; `stop` arriving on the same edge as the timeout wins (normal result).
- Back-to-back: result accepted at edge R → IDLE; next pop at R+1; one ALU op in flight at any time.
- `bgn` is exactly one cycle per command; never asserted while `res_valid=1`.

## Test plan
- Single add: push `sel=5'b00000`, a=5, b=5; ALU model raises `stop` 3 cycles after `bgn` with out=10 -> `bgn` one cycle, `res_valid` with `res_data=10`, `res_sel=0`, `res_err=0`, push-to-valid 5 cycles.
- FIFO full: push 5 commands with `res_ready=0`, DEPTH=4 -> 1 popped + 4 queued; 6th push sees `cmd_ready=0`; release `res_ready` -> results in push order, `sel` values match.
- Timeout: TIMEOUT=8, ALU model never raises `stop` -> `res_valid` 8 cycles after WAIT entry, `res_data=0`, `res_err=1`, `err_cnt=1`; next command proceeds normally.
- Stale stop: hold `stop=1` continuously before and after `bgn` for `sel=5'b00011`, a=15, b=5 -> result captured in first WAIT cycle with current `out`; one result per command, no double capture.
- Backpressure: `res_ready` low 10 cycles -> `res_*` stable, no new `bgn` until accept.
- Reset mid-WAIT: assert `rst_b=0` with 2 queued -> all outputs to reset values immediately, `cmd_ready=1`, no `res_valid` after release.
